// File: rtl/sb_pkg.sv
// Shared definitions for the simple-bus (sb) arbiter slice: bus widths,
// path FSM state encoding and master identifiers.
package sb_pkg;

    localparam int SB_AW = 32;
    localparam int SB_DW = 32;
    localparam int SB_SW = 4;

    // Per-path arbitration state.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } sb_state_e;

    // Master identifiers (m0 = instruction fetch, m1 = load/store).
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/sb_arb_ch.sv
// One arbitration channel: picks a winner among two masters for the
// request phase, holds ownership through the response phase, and keeps a
// round-robin pointer. Payload muxing lives in the parent.
module sb_arb_ch
    import sb_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,         // request valid per master
    input  logic       req_ready,   // slave accepts the forwarded request
    input  logic       rsp_valid,   // slave response valid
    input  logic [1:0] rsp_ready,   // response accept per master
    output logic       fwd_en,      // a request is being forwarded to the slave
    output logic       fwd_sel,     // which master's request is forwarded
    output logic       rsp_en,      // response phase: route response to owner
    output logic       owner        // master owning the response phase
);

    sb_state_e state_reg;
    logic      owner_reg;
    logic      ptr_reg;
    logic      win;
    logic      hs_req;
    logic      hs_rsp;

    // Winner selection, forwarding enable and handshake detection.
    always_comb begin
        win     = M0;
        fwd_en  = 1'b0;
        fwd_sel = owner_reg;
        case (req)
            2'b10:   win = M1;
            2'b11:   win = FIXED_PRIO ? M0 : ptr_reg;
            default: win = M0;
        endcase
        case (state_reg)
            ST_IDLE: begin
                fwd_en  = |req;
                fwd_sel = win;
            end
            // Owner is frozen: the other master cannot disturb the slave side.
            ST_ADDR: fwd_en = req[owner_reg];
            default: fwd_en = 1'b0;
        endcase
        rsp_en = (state_reg == ST_DATA);
        hs_req = fwd_en & req_ready;
        hs_rsp = rsp_en & rsp_valid & rsp_ready[owner_reg];
    end

    assign owner = owner_reg;

    // Path FSM, owner register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            owner_reg <= M0;
            ptr_reg   <= M0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (|req) begin
                        owner_reg <= win;
                        state_reg <= hs_req ? ST_DATA : ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (hs_req) state_reg <= ST_DATA;
                end
                ST_DATA: begin
                    if (hs_rsp) state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
            // Pointer moves to the master that lost this grant.
            if (hs_req) ptr_reg <= ~fwd_sel;
        end
    end

endmodule

// File: rtl/sb_arb_2m1s.sv
// Two-master / one-slave sb arbiter. Read and write paths each use an
// independent sb_arb_ch; this level only steers payloads and handshakes.
module sb_arb_2m1s
    import sb_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    // master 0
    input  logic              sb_arvalid_m0,
    input  logic [SB_AW-1:0]  sb_araddr_m0,
    output logic              sb_arready_m0,
    output logic              sb_rvalid_m0,
    output logic [SB_DW-1:0]  sb_rdata_m0,
    input  logic              sb_rready_m0,
    input  logic              sb_wvalid_m0,
    input  logic [SB_AW-1:0]  sb_waddr_m0,
    input  logic [SB_DW-1:0]  sb_wdata_m0,
    input  logic [SB_SW-1:0]  sb_wstrb_m0,
    output logic              sb_wready_m0,
    output logic              sb_bvalid_m0,
    output logic              sb_bresp_m0,
    input  logic              sb_bready_m0,
    // master 1
    input  logic              sb_arvalid_m1,
    input  logic [SB_AW-1:0]  sb_araddr_m1,
    output logic              sb_arready_m1,
    output logic              sb_rvalid_m1,
    output logic [SB_DW-1:0]  sb_rdata_m1,
    input  logic              sb_rready_m1,
    input  logic              sb_wvalid_m1,
    input  logic [SB_AW-1:0]  sb_waddr_m1,
    input  logic [SB_DW-1:0]  sb_wdata_m1,
    input  logic [SB_SW-1:0]  sb_wstrb_m1,
    output logic              sb_wready_m1,
    output logic              sb_bvalid_m1,
    output logic              sb_bresp_m1,
    input  logic              sb_bready_m1,
    // slave
    output logic              sb_arvalid_s0,
    output logic [SB_AW-1:0]  sb_araddr_s0,
    input  logic              sb_arready_s0,
    input  logic              sb_rvalid_s0,
    input  logic [SB_DW-1:0]  sb_rdata_s0,
    output logic              sb_rready_s0,
    output logic              sb_wvalid_s0,
    output logic [SB_AW-1:0]  sb_waddr_s0,
    output logic [SB_DW-1:0]  sb_wdata_s0,
    output logic [SB_SW-1:0]  sb_wstrb_s0,
    input  logic              sb_wready_s0,
    input  logic              sb_bvalid_s0,
    input  logic              sb_bresp_s0,
    output logic              sb_bready_s0
);

    // Master-indexed views of the scalar ports.
    logic [1:0]       ar_req;
    logic [1:0]       r_rdy;
    logic [1:0]       w_req;
    logic [1:0]       b_rdy;
    logic [SB_AW-1:0] ar_addr [2];
    logic [SB_AW-1:0] w_addr  [2];
    logic [SB_DW-1:0] w_data  [2];
    logic [SB_SW-1:0] w_strb  [2];

    logic [1:0]       ar_rdy_o;
    logic [1:0]       r_vld_o;
    logic [SB_DW-1:0] r_data_o [2];
    logic [1:0]       w_rdy_o;
    logic [1:0]       b_vld_o;
    logic [1:0]       b_resp_o;

    logic rd_fwd_en, rd_fwd_sel, rd_rsp_en, rd_owner;
    logic wr_fwd_en, wr_fwd_sel, wr_rsp_en, wr_owner;

    assign ar_req     = {sb_arvalid_m1, sb_arvalid_m0};
    assign r_rdy      = {sb_rready_m1,  sb_rready_m0};
    assign w_req      = {sb_wvalid_m1,  sb_wvalid_m0};
    assign b_rdy      = {sb_bready_m1,  sb_bready_m0};
    assign ar_addr[0] = sb_araddr_m0;
    assign ar_addr[1] = sb_araddr_m1;
    assign w_addr[0]  = sb_waddr_m0;
    assign w_addr[1]  = sb_waddr_m1;
    assign w_data[0]  = sb_wdata_m0;
    assign w_data[1]  = sb_wdata_m1;
    assign w_strb[0]  = sb_wstrb_m0;
    assign w_strb[1]  = sb_wstrb_m1;

    sb_arb_ch #(.FIXED_PRIO(FIXED_PRIO)) u_rd_ch (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (ar_req),
        .req_ready (sb_arready_s0),
        .rsp_valid (sb_rvalid_s0),
        .rsp_ready (r_rdy),
        .fwd_en    (rd_fwd_en),
        .fwd_sel   (rd_fwd_sel),
        .rsp_en    (rd_rsp_en),
        .owner     (rd_owner)
    );

    sb_arb_ch #(.FIXED_PRIO(FIXED_PRIO)) u_wr_ch (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (w_req),
        .req_ready (sb_wready_s0),
        .rsp_valid (sb_bvalid_s0),
        .rsp_ready (b_rdy),
        .fwd_en    (wr_fwd_en),
        .fwd_sel   (wr_fwd_sel),
        .rsp_en    (wr_rsp_en),
        .owner     (wr_owner)
    );

    // Slave-side request payloads come from the forwarded master only.
    assign sb_arvalid_s0 = rd_fwd_en;
    assign sb_araddr_s0  = rd_fwd_en ? ar_addr[rd_fwd_sel] : '0;
    assign sb_rready_s0  = rd_rsp_en & r_rdy[rd_owner];
    assign sb_wvalid_s0  = wr_fwd_en;
    assign sb_waddr_s0   = wr_fwd_en ? w_addr[wr_fwd_sel] : '0;
    assign sb_wdata_s0   = wr_fwd_en ? w_data[wr_fwd_sel] : '0;
    assign sb_wstrb_s0   = wr_fwd_en ? w_strb[wr_fwd_sel] : '0;
    assign sb_bready_s0  = wr_rsp_en & b_rdy[wr_owner];

    // Per-master handshake and response steering; non-owners see zeros.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_mst
            assign ar_rdy_o[gi] = rd_fwd_en & (rd_fwd_sel == 1'(gi)) & sb_arready_s0;
            assign r_vld_o[gi]  = rd_rsp_en & (rd_owner == 1'(gi)) & sb_rvalid_s0;
            assign r_data_o[gi] = (rd_rsp_en & (rd_owner == 1'(gi))) ? sb_rdata_s0 : '0;
            assign w_rdy_o[gi]  = wr_fwd_en & (wr_fwd_sel == 1'(gi)) & sb_wready_s0;
            assign b_vld_o[gi]  = wr_rsp_en & (wr_owner == 1'(gi)) & sb_bvalid_s0;
            assign b_resp_o[gi] = wr_rsp_en & (wr_owner == 1'(gi)) & sb_bresp_s0;
        end
    endgenerate

    assign sb_arready_m0 = ar_rdy_o[0];
    assign sb_arready_m1 = ar_rdy_o[1];
    assign sb_rvalid_m0  = r_vld_o[0];
    assign sb_rvalid_m1  = r_vld_o[1];
    assign sb_rdata_m0   = r_data_o[0];
    assign sb_rdata_m1   = r_data_o[1];
    assign sb_wready_m0  = w_rdy_o[0];
    assign sb_wready_m1  = w_rdy_o[1];
    assign sb_bvalid_m0  = b_vld_o[0];
    assign sb_bvalid_m1  = b_vld_o[1];
    assign sb_bresp_m0   = b_resp_o[0];
    assign sb_bresp_m1   = b_resp_o[1];

endmodule

// File: tb/tb_sb_arb_2m1s.sv
// Directed bench for sb_arb_2m1s (round-robin build): the bench plays both
// masters and the slave and checks steering against hand-computed values.
module tb_sb_arb_2m1s;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sb_arvalid_m0, sb_arvalid_m1;
    logic [31:0] sb_araddr_m0, sb_araddr_m1;
    logic        sb_arready_m0, sb_arready_m1;
    logic        sb_rvalid_m0, sb_rvalid_m1;
    logic [31:0] sb_rdata_m0, sb_rdata_m1;
    logic        sb_rready_m0, sb_rready_m1;
    logic        sb_wvalid_m0, sb_wvalid_m1;
    logic [31:0] sb_waddr_m0, sb_waddr_m1, sb_wdata_m0, sb_wdata_m1;
    logic [3:0]  sb_wstrb_m0, sb_wstrb_m1;
    logic        sb_wready_m0, sb_wready_m1;
    logic        sb_bvalid_m0, sb_bvalid_m1;
    logic        sb_bresp_m0, sb_bresp_m1;
    logic        sb_bready_m0, sb_bready_m1;
    logic        sb_arvalid_s0;
    logic [31:0] sb_araddr_s0;
    logic        sb_arready_s0;
    logic        sb_rvalid_s0;
    logic [31:0] sb_rdata_s0;
    logic        sb_rready_s0;
    logic        sb_wvalid_s0;
    logic [31:0] sb_waddr_s0, sb_wdata_s0;
    logic [3:0]  sb_wstrb_s0;
    logic        sb_wready_s0;
    logic        sb_bvalid_s0, sb_bresp_s0;
    logic        sb_bready_s0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sb_arb_2m1s dut (
        .clk(clk), .rst_n(rst_n),
        .sb_arvalid_m0(sb_arvalid_m0), .sb_araddr_m0(sb_araddr_m0), .sb_arready_m0(sb_arready_m0),
        .sb_rvalid_m0(sb_rvalid_m0), .sb_rdata_m0(sb_rdata_m0), .sb_rready_m0(sb_rready_m0),
        .sb_wvalid_m0(sb_wvalid_m0), .sb_waddr_m0(sb_waddr_m0), .sb_wdata_m0(sb_wdata_m0),
        .sb_wstrb_m0(sb_wstrb_m0), .sb_wready_m0(sb_wready_m0), .sb_bvalid_m0(sb_bvalid_m0),
        .sb_bresp_m0(sb_bresp_m0), .sb_bready_m0(sb_bready_m0),
        .sb_arvalid_m1(sb_arvalid_m1), .sb_araddr_m1(sb_araddr_m1), .sb_arready_m1(sb_arready_m1),
        .sb_rvalid_m1(sb_rvalid_m1), .sb_rdata_m1(sb_rdata_m1), .sb_rready_m1(sb_rready_m1),
        .sb_wvalid_m1(sb_wvalid_m1), .sb_waddr_m1(sb_waddr_m1), .sb_wdata_m1(sb_wdata_m1),
        .sb_wstrb_m1(sb_wstrb_m1), .sb_wready_m1(sb_wready_m1), .sb_bvalid_m1(sb_bvalid_m1),
        .sb_bresp_m1(sb_bresp_m1), .sb_bready_m1(sb_bready_m1),
        .sb_arvalid_s0(sb_arvalid_s0), .sb_araddr_s0(sb_araddr_s0), .sb_arready_s0(sb_arready_s0),
        .sb_rvalid_s0(sb_rvalid_s0), .sb_rdata_s0(sb_rdata_s0), .sb_rready_s0(sb_rready_s0),
        .sb_wvalid_s0(sb_wvalid_s0), .sb_waddr_s0(sb_waddr_s0), .sb_wdata_s0(sb_wdata_s0),
        .sb_wstrb_s0(sb_wstrb_s0), .sb_wready_s0(sb_wready_s0), .sb_bvalid_s0(sb_bvalid_s0),
        .sb_bresp_s0(sb_bresp_s0), .sb_bready_s0(sb_bready_s0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        sb_arvalid_m0 = 0; sb_arvalid_m1 = 0; sb_araddr_m0 = 0; sb_araddr_m1 = 0;
        sb_rready_m0 = 0; sb_rready_m1 = 0;
        sb_wvalid_m0 = 0; sb_wvalid_m1 = 0; sb_waddr_m0 = 0; sb_waddr_m1 = 0;
        sb_wdata_m0 = 0; sb_wdata_m1 = 0; sb_wstrb_m0 = 0; sb_wstrb_m1 = 0;
        sb_bready_m0 = 0; sb_bready_m1 = 0;
        sb_arready_s0 = 0; sb_rvalid_s0 = 0; sb_rdata_s0 = 0;
        sb_wready_s0 = 0; sb_bvalid_s0 = 0; sb_bresp_s0 = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        step();
        rst_n = 1;
        step();
    endtask

    initial begin
        logic exp_m1;
        rst_n = 0;
        idle_inputs();
        #2;
        // Reset state
        chk("rst_arready_m0", 32'(sb_arready_m0), 0);
        chk("rst_rvalid_m0", 32'(sb_rvalid_m0), 0);
        chk("rst_wready_m1", 32'(sb_wready_m1), 0);
        chk("rst_bvalid_m1", 32'(sb_bvalid_m1), 0);
        chk("rst_rready_s0", 32'(sb_rready_s0), 0);
        chk("rst_bready_s0", 32'(sb_bready_s0), 0);
        chk("rst_arvalid_s0", 32'(sb_arvalid_s0), 0);
        chk("rst_wvalid_s0", 32'(sb_wvalid_s0), 0);
        step();
        rst_n = 1;
        step();

        // Response while IDLE is ignored
        sb_rvalid_s0 = 1; sb_rdata_s0 = 32'h0BAD_0BAD; sb_rready_m0 = 1;
        #1;
        chk("idle_rsp_rready_s0", 32'(sb_rready_s0), 0);
        chk("idle_rsp_rvalid_m0", 32'(sb_rvalid_m0), 0);
        idle_inputs();

        // Single m0 read
        sb_arvalid_m0 = 1; sb_araddr_m0 = 32'h4000_0010; sb_arready_s0 = 1;
        #1;
        $display("[TB] m0 read addr=%h", sb_araddr_m0);
        chk("t1_arvalid_s0", 32'(sb_arvalid_s0), 1);
        chk("t1_araddr_s0", sb_araddr_s0, 32'h4000_0010);
        chk("t1_arready_m0", 32'(sb_arready_m0), 1);
        chk("t1_arready_m1", 32'(sb_arready_m1), 0);
        step();
        sb_arvalid_m0 = 0; sb_rready_m0 = 1;
        #1;
        chk("t1_data_arvalid_s0", 32'(sb_arvalid_s0), 0);
        chk("t1_wait_rvalid_m0", 32'(sb_rvalid_m0), 0);
        step();
        sb_rvalid_s0 = 1; sb_rdata_s0 = 32'hDEAD_BEEF;
        #1;
        chk("t1_rvalid_m0", 32'(sb_rvalid_m0), 1);
        chk("t1_rdata_m0", sb_rdata_m0, 32'hDEAD_BEEF);
        chk("t1_rvalid_m1", 32'(sb_rvalid_m1), 0);
        chk("t1_rdata_m1", sb_rdata_m1, 0);
        chk("t1_rready_s0", 32'(sb_rready_s0), 1);
        step();
        sb_rvalid_s0 = 0; sb_arvalid_m1 = 1; sb_araddr_m1 = 32'h0000_0A00;
        #1;
        chk("t1_back_idle_arready_m1", 32'(sb_arready_m1), 1);
        chk("t1_back_idle_rvalid_m0", 32'(sb_rvalid_m0), 0);

        // Simultaneous requests, round-robin
        do_reset();
        sb_arvalid_m0 = 1; sb_araddr_m0 = 32'h100;
        sb_arvalid_m1 = 1; sb_araddr_m1 = 32'h200;
        sb_arready_s0 = 1; sb_rready_m0 = 1; sb_rready_m1 = 1;
        #1;
        $display("[TB] simultaneous reads m0/m1");
        chk("t2_araddr_s0", sb_araddr_s0, 32'h100);
        chk("t2_arready_m0", 32'(sb_arready_m0), 1);
        chk("t2_arready_m1", 32'(sb_arready_m1), 0);
        step();
        sb_arvalid_m0 = 0; sb_rvalid_s0 = 1; sb_rdata_s0 = 32'h11;
        #1;
        chk("t2_data_arready_m1", 32'(sb_arready_m1), 0);
        chk("t2_rdata_m0", sb_rdata_m0, 32'h11);
        chk("t2_rvalid_m1", 32'(sb_rvalid_m1), 0);
        step();
        sb_rvalid_s0 = 0;
        #1;
        chk("t2_m1_araddr_s0", sb_araddr_s0, 32'h200);
        chk("t2_m1_arready_m1", 32'(sb_arready_m1), 1);
        step();
        sb_arvalid_m1 = 0; sb_rvalid_s0 = 1; sb_rdata_s0 = 32'h22;
        #1;
        chk("t2_rdata_m1", sb_rdata_m1, 32'h22);
        chk("t2_rdata_m0", sb_rdata_m0, 0);
        step();
        sb_rvalid_s0 = 0;
        // Three more simultaneous requests: m0, m1, m0
        for (int k = 0; k < 3; k++) begin
            exp_m1 = (k == 1);
            sb_arvalid_m0 = 1; sb_arvalid_m1 = 1;
            #1;
            $display("[TB] rr round %0d grant m0=%0b m1=%0b", k, sb_arready_m0, sb_arready_m1);
            chk("t2_rr_arready_m0", 32'(sb_arready_m0), 32'(!exp_m1));
            chk("t2_rr_arready_m1", 32'(sb_arready_m1), 32'(exp_m1));
            step();
            if (exp_m1) sb_arvalid_m1 = 0; else sb_arvalid_m0 = 0;
            sb_rvalid_s0 = 1;
            step();
            sb_rvalid_s0 = 0;
        end

        // m0 stalled by slave; m1 arrives and must not disturb the address
        do_reset();
        sb_arvalid_m0 = 1; sb_araddr_m0 = 32'h300;
        #1;
        $display("[TB] stalled m0 read, m1 contends");
        chk("t3_c0_araddr_s0", sb_araddr_s0, 32'h300);
        chk("t3_c0_arready_m0", 32'(sb_arready_m0), 0);
        step();
        sb_arvalid_m1 = 1; sb_araddr_m1 = 32'h400;
        #1;
        chk("t3_c1_araddr_s0", sb_araddr_s0, 32'h300);
        chk("t3_c1_arready_m1", 32'(sb_arready_m1), 0);
        step();
        #1;
        chk("t3_c2_araddr_s0", sb_araddr_s0, 32'h300);
        chk("t3_c2_arvalid_s0", 32'(sb_arvalid_s0), 1);
        sb_arready_s0 = 1;
        #1;
        chk("t3_acc_arready_m0", 32'(sb_arready_m0), 1);
        chk("t3_acc_arready_m1", 32'(sb_arready_m1), 0);
        step();
        sb_arvalid_m0 = 0;
        // rready_m0 held low for 4 cycles while slave has data
        sb_rvalid_s0 = 1; sb_rdata_s0 = 32'hCAFE_0001; sb_rready_m0 = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            $display("[TB] backpressure cycle %0d rdata_m0=%h", k, sb_rdata_m0);
            chk("t5_rvalid_m0", 32'(sb_rvalid_m0), 1);
            chk("t5_rdata_m0", sb_rdata_m0, 32'hCAFE_0001);
            chk("t5_rready_s0", 32'(sb_rready_s0), 0);
            chk("t5_arready_m1", 32'(sb_arready_m1), 0);
            chk("t5_arvalid_s0", 32'(sb_arvalid_s0), 0);
            step();
        end
        sb_rready_m0 = 1;
        #1;
        chk("t5_rready_s0_mirror", 32'(sb_rready_s0), 1);
        step();
        sb_rvalid_s0 = 0; sb_rready_m0 = 0;
        #1;
        chk("t3_m1_arready_m1", 32'(sb_arready_m1), 1);
        chk("t3_m1_araddr_s0", sb_araddr_s0, 32'h400);
        step();
        sb_arvalid_m1 = 0;

        // Reset while read path in DATA (owner m1)
        sb_rvalid_s0 = 1; sb_rdata_s0 = 32'h7777_7777; sb_rready_m1 = 1;
        #1;
        chk("t6_pre_rvalid_m1", 32'(sb_rvalid_m1), 1);
        rst_n = 0;
        #1;
        $display("[TB] async reset during DATA");
        chk("t6_rst_rvalid_m1", 32'(sb_rvalid_m1), 0);
        chk("t6_rst_rdata_m1", sb_rdata_m1, 0);
        chk("t6_rst_rready_s0", 32'(sb_rready_s0), 0);
        step();
        rst_n = 1; sb_rvalid_s0 = 0; sb_rready_m1 = 0;
        step();
        sb_arvalid_m1 = 1; sb_araddr_m1 = 32'h0000_0BB0; sb_arready_s0 = 1;
        #1;
        chk("t6_after_arready_m1", 32'(sb_arready_m1), 1);
        chk("t6_after_araddr_s0", sb_araddr_s0, 32'h0000_0BB0);

        // Concurrent m1 write and m0 read
        do_reset();
        sb_arvalid_m0 = 1; sb_araddr_m0 = 32'h500; sb_arready_s0 = 1;
        sb_wvalid_m1 = 1; sb_waddr_m1 = 32'h8000_0000; sb_wdata_m1 = 32'h1234_5678;
        sb_wstrb_m1 = 4'b0011; sb_wready_s0 = 1;
        #1;
        $display("[TB] m1 write addr=%h data=%h with m0 read", sb_waddr_m1, sb_wdata_m1);
        chk("t4_arvalid_s0", 32'(sb_arvalid_s0), 1);
        chk("t4_wvalid_s0", 32'(sb_wvalid_s0), 1);
        chk("t4_waddr_s0", sb_waddr_s0, 32'h8000_0000);
        chk("t4_wdata_s0", sb_wdata_s0, 32'h1234_5678);
        chk("t4_wstrb_s0", 32'(sb_wstrb_s0), 32'h3);
        chk("t4_wready_m1", 32'(sb_wready_m1), 1);
        chk("t4_wready_m0", 32'(sb_wready_m0), 0);
        chk("t4_arready_m0", 32'(sb_arready_m0), 1);
        step();
        sb_arvalid_m0 = 0; sb_wvalid_m1 = 0;
        sb_bvalid_s0 = 1; sb_bresp_s0 = 1; sb_bready_m1 = 1; sb_bready_m0 = 1;
        sb_rvalid_s0 = 1; sb_rdata_s0 = 32'h55; sb_rready_m0 = 1;
        #1;
        chk("t4_bvalid_m1", 32'(sb_bvalid_m1), 1);
        chk("t4_bresp_m1", 32'(sb_bresp_m1), 1);
        chk("t4_bvalid_m0", 32'(sb_bvalid_m0), 0);
        chk("t4_bresp_m0", 32'(sb_bresp_m0), 0);
        chk("t4_bready_s0", 32'(sb_bready_s0), 1);
        chk("t4_rdata_m0", sb_rdata_m0, 32'h55);
        step();
        idle_inputs();
        #1;
        chk("t4_end_bvalid_m1", 32'(sb_bvalid_m1), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sb_arb_2m1s.md
Name: sb_arb_2m1s

Overview:
- Two-master to one-slave arbiter for the simple bus (sb).
- Shares one sb slave port (typically the 1m4s decoder's master port) between the RV32I instruction-fetch port (m0) and data/load-store port (m1).
- Read path and write path are arbitrated independently.
- Each path allows one outstanding transaction; the winning master owns its path until its response handshake completes.

Parameters:
FIXED_PRIO, 0, 0 = round-robin between m0/m1; 1 = m0 always wins simultaneous requests.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
sb_arvalid_m<n>, sb_araddr_m<n>  in  1, 32  read address request from master n (n=0,1)
sb_arready_m<n>  out  1  read address accept to master n
sb_rvalid_m<n>, sb_rdata_m<n>  out  1, 32  read data to master n
sb_rready_m<n>  in  1  read data accept from master n
sb_wvalid_m<n>, sb_waddr_m<n>, sb_wdata_m<n>, sb_wstrb_m<n>  in  1, 32, 32, 4  write request from master n
sb_wready_m<n>  out  1  write accept to master n
sb_bvalid_m<n>, sb_bresp_m<n>  out  1, 1  write response to master n
sb_bready_m<n>  in  1  write response accept from master n
sb_arvalid_s0, sb_araddr_s0  out  1, 32  read address to slave
sb_arready_s0  in  1  slave read address accept
sb_rvalid_s0, sb_rdata_s0  in  1, 32  slave read data
sb_rready_s0  out  1  read data accept to slave
sb_wvalid_s0, sb_waddr_s0, sb_wdata_s0, sb_wstrb_s0  out  1, 32, 32, 4  write request to slave
sb_wready_s0  in  1  slave write accept
sb_bvalid_s0, sb_bresp_s0  in  1, 1  slave write response
sb_bready_s0  out  1  response accept to slave

Behaviour:
- Reset (rst_n low, asynchronous; clock clk): both path FSMs go to IDLE, grant = none, priority pointer = m0.
  - All master-side outputs are 0.
  - sb_rready_s0 and sb_bready_s0 are 0.
  - Slave-side valids are 0 while no master requests.
- Read FSM states: IDLE, ADDR, DATA. The write FSM is identical, using w*/b* signals in place of ar*/r*.
- IDLE:
  - Winner = requesting master if only one requests.
  - If both request: pointer master (round-robin) or m0 (FIXED_PRIO=1).
  - Winner's valid/addr are forwarded combinationally to the slave; winner's ready = sb_arready_s0. Loser's ready = 0.
  - On address handshake: go to DATA and register owner. Otherwise, if any request: go to ADDR and register owner.
- ADDR: owner is frozen; only the owner's request is forwarded, so slave-side valid/addr stay stable even if the other master raises valid. Address handshake -> DATA.
- DATA:
  - sb_arvalid_s0 = 0; both arready_m = 0.
  - Owner's rvalid/rdata = slave's; sb_rready_s0 = owner's rready. Non-owner rvalid = 0 and rdata = 0.
  - On r handshake (rvalid & rready): go to IDLE.
- Latency and throughput:
  - New request to the same path is arbitrated the cycle after the response handshake, giving a 1-cycle bubble.
  - Address path adds 0 cycles (combinational); max throughput is one transaction per 2 cycles plus slave latency.
- Round-robin pointer: updated on each address/write handshake to point to the master that did NOT win.
- Write path pointer is independent of the read pointer.
- Read and write paths may be owned by different masters simultaneously.
- Response arriving in IDLE/ADDR (protocol violation): ignored; rready_s0/bready_s0 held 0.
- Reset mid-transaction: state dropped and path returns to IDLE. Slave shares rst_n, so no orphan response occurs.
- Masters must hold valid/addr/data stable until ready; the arbiter does not re-arbitrate while a request is pending.

Decomposition:
- Package sb_pkg: SB_AW=32, SB_DW=32, SB_SW=4, FSM state encoding (ST_IDLE=2'd0, ST_ADDR=2'd1, ST_DATA=2'd2), master ids.
- Sub-module sb_arb_ch: one request/response arbitration FSM plus pointer. It outputs owner/grant and stage flags and is instantiated twice (read, write).
- Top-level sb_arb_2m1s does payload muxing only.

Test Plan:
- Single m0 read 0x4000_0010, slave arready same cycle, rdata 0xDEADBEEF 2 cycles later -> m0 gets arready at cycle 0 and rvalid/rdata 0xDEADBEEF; m1 rvalid stays 0; FSM returns to IDLE.
- Both masters arvalid in same cycle after reset, FIXED_PRIO=0, slave always ready -> m0 granted first, then m1 granted after m0's r handshake plus 1 cycle; then alternating m0,m1,m0 over 3 further simultaneous requests.
- m0 arvalid with slave arready low for 3 cycles; m1 raises arvalid in cycle 1 -> sb_araddr_s0 stays m0's address all 3 cycles; m1 arready = 0 until m0 completes.
- Concurrent m1 write (addr 0x8000_0000, wdata 0x1234_5678, wstrb 4'b0011) and m0 read -> both forwarded in same cycle; bresp 1 is routed only to m1; m0 bvalid = 0.
- rready_m0 held low 4 cycles while slave rvalid high -> rdata held; no new AR accepted; sb_rready_s0 mirrors rready_m0.
- rst_n asserted while read path in DATA -> all master outputs 0 immediately; after release, m1 request granted first (pointer = m0 but only m1 requests).
